// File: rtl/cell_access_ctrl_if.sv
// rtl/cell_access_ctrl_if.sv - stream, write-request and RAM port bundle for cell_access_ctrl
// master is the controller side; slave is the client/RAM side.
interface cell_access_ctrl_if #(
    parameter int DATA_WIDTH = 96,
    parameter int ADDR_WIDTH = 8
);
    logic                  rd_start;
    logic                  rd_busy;
    logic                  rd_done;
    logic                  rd_valid;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ADDR_WIDTH-1:0] rd_index;
    logic [ADDR_WIDTH-1:0] cell_count;
    logic                  cnt_err;

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  wr_grant;

    logic [ADDR_WIDTH-1:0] mem_address;
    logic [DATA_WIDTH-1:0] mem_data;
    logic                  mem_rden;
    logic                  mem_wren;
    logic [DATA_WIDTH-1:0] mem_q;

    modport master (
        input  rd_start, wr_req, wr_addr, wr_data, mem_q,
        output rd_busy, rd_done, rd_valid, rd_data, rd_index, cell_count, cnt_err,
        output wr_grant, mem_address, mem_data, mem_rden, mem_wren
    );

    modport slave (
        output rd_start, wr_req, wr_addr, wr_data, mem_q,
        input  rd_busy, rd_done, rd_valid, rd_data, rd_index, cell_count, cnt_err,
        input  wr_grant, mem_address, mem_data, mem_rden, mem_wren
    );
endinterface

// File: rtl/cell_access_ctrl.sv
// rtl/cell_access_ctrl.sv - single-port cell RAM sequencer: streams particles, arbitrates writebacks
// Word 0 holds the particle count; the RAM returns data two cycles after the address cycle.
module cell_access_ctrl #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220
) (
    input  logic                clk,
    input  logic                rst,
    cell_access_ctrl_if.master  bus
);

    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);
    localparam logic [ADDR_WIDTH:0]   NUM_WORDS = (ADDR_WIDTH + 1)'(PARTICLE_NUM);

    typedef enum logic [2:0] {
        IDLE,
        CNT_RD,
        CNT_WAIT,
        STREAM,
        DRAIN,
        DONE
    } state_t;

    state_t                state, state_d;
    logic                  rd_pend, rd_pend_d;
    logic                  cnt_wait, cnt_wait_d;

    logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
    logic [DATA_WIDTH-1:0] mem_data_q, mem_data_d;
    logic                  mem_rden_q, mem_rden_d;
    logic                  mem_wren_q, mem_wren_d;

    logic [ADDR_WIDTH-1:0] cell_count_q, cell_count_d;
    logic                  cnt_err_q, cnt_err_d;
    logic                  wr_grant;

    // Outstanding stream reads: stage 0 = address cycle + 1, stage 1 = data on mem_q
    logic [1:0]            pipe_v;
    logic [ADDR_WIDTH-1:0] pipe_idx0, pipe_idx1;

    logic                  rd_valid_q;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [ADDR_WIDTH-1:0] rd_index_q;

    logic [ADDR_WIDTH-1:0] raw_count;
    logic                  count_over;
    logic [ADDR_WIDTH-1:0] clamped_count;

    assign raw_count     = bus.mem_q[ADDR_WIDTH-1:0];
    assign count_over    = raw_count > MAX_COUNT;
    assign clamped_count = count_over ? MAX_COUNT : raw_count;

    always_comb begin
        state_d       = state;
        rd_pend_d     = rd_pend;
        cnt_wait_d    = 1'b0;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_rden_d    = 1'b0;
        mem_wren_d    = 1'b0;
        cell_count_d  = cell_count_q;
        cnt_err_d     = cnt_err_q;
        wr_grant      = 1'b0;

        case (state)
            IDLE: begin
                if (bus.wr_req) begin
                    // Writes win ties; a start arriving now waits in rd_pend
                    wr_grant      = 1'b1;
                    rd_pend_d     = rd_pend | bus.rd_start;
                    mem_address_d = bus.wr_addr;
                    mem_data_d    = bus.wr_data;
                    if ({1'b0, bus.wr_addr} < NUM_WORDS) begin
                        mem_wren_d = 1'b1;
                    end else begin
                        cnt_err_d = 1'b1;
                    end
                end else if (rd_pend || bus.rd_start) begin
                    state_d       = CNT_RD;
                    rd_pend_d     = 1'b0;
                    mem_address_d = '0;
                    mem_rden_d    = 1'b1;
                end
            end
            CNT_RD: begin
                state_d = CNT_WAIT;
            end
            CNT_WAIT: begin
                cnt_wait_d = ~cnt_wait;
                if (cnt_wait) begin
                    cnt_wait_d   = 1'b0;
                    cell_count_d = clamped_count;
                    if (count_over) begin
                        cnt_err_d = 1'b1;
                    end
                    if (clamped_count == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d       = STREAM;
                        mem_address_d = ADDR_WIDTH'(1);
                        mem_rden_d    = 1'b1;
                    end
                end
            end
            STREAM: begin
                if (mem_address_q == cell_count_q) begin
                    state_d = DRAIN;
                end else begin
                    mem_address_d = mem_address_q + ADDR_WIDTH'(1);
                    mem_rden_d    = 1'b1;
                end
            end
            DRAIN: begin
                if (pipe_v == 2'b00) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            rd_pend       <= 1'b0;
            cnt_wait      <= 1'b0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_rden_q    <= 1'b0;
            mem_wren_q    <= 1'b0;
            cell_count_q  <= '0;
            cnt_err_q     <= 1'b0;
            pipe_v        <= 2'b00;
            pipe_idx0     <= '0;
            pipe_idx1     <= '0;
            rd_valid_q    <= 1'b0;
            rd_data_q     <= '0;
            rd_index_q    <= '0;
        end else begin
            state         <= state_d;
            rd_pend       <= rd_pend_d;
            cnt_wait      <= cnt_wait_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_rden_q    <= mem_rden_d;
            mem_wren_q    <= mem_wren_d;
            cell_count_q  <= cell_count_d;
            cnt_err_q     <= cnt_err_d;
            pipe_v[0]     <= (state == STREAM);
            pipe_idx0     <= mem_address_q;
            pipe_v[1]     <= pipe_v[0];
            pipe_idx1     <= pipe_idx0;
            rd_valid_q    <= pipe_v[1];
            if (pipe_v[1]) begin
                rd_data_q  <= bus.mem_q;
                rd_index_q <= pipe_idx1;
            end
        end
    end

    assign bus.rd_busy     = (state != IDLE);
    assign bus.rd_done     = (state == DONE);
    assign bus.rd_valid    = rd_valid_q;
    assign bus.rd_data     = rd_data_q;
    assign bus.rd_index    = rd_index_q;
    assign bus.cell_count  = cell_count_q;
    assign bus.cnt_err     = cnt_err_q;
    assign bus.wr_grant    = wr_grant;
    assign bus.mem_address = mem_address_q;
    assign bus.mem_data    = mem_data_q;
    assign bus.mem_rden    = mem_rden_q;
    assign bus.mem_wren    = mem_wren_q;

endmodule

// File: doc/cell_access_ctrl.md
# cell_access_ctrl

Sequencer and arbiter for one single-port position cell memory (96-bit `{posz, posy, posx}` words, word 0 = particle count, 2-cycle read latency). Streams all particles of the cell to the force-evaluation side on request. Shares the single port with motion-update writebacks so that reads and writes never collide. Sits between the position cache / force pipeline and one cell RAM instance.

## Interface
Parameters:
- `DATA_WIDTH`, 96, width of one memory word.
- `ADDR_WIDTH`, 8, memory address width.
- `PARTICLE_NUM`, 220, number of memory words. Maximum legal count is `PARTICLE_NUM-1`.

Ports:
- `clk`  in  1  single clock for block and RAM.
- `rst`  in  1  synchronous, active-high reset.
- `rd_start`  in  1  one-cycle pulse: stream the cell.
- `rd_busy`  out  1  stream in progress.
- `rd_done`  out  1  one-cycle pulse at stream end.
- `rd_valid`  out  1  `rd_data`/`rd_index` valid this cycle.
- `rd_data`  out  DATA_WIDTH  particle word.
- `rd_index`  out  ADDR_WIDTH  particle address, 1..N.
- `cell_count`  out  ADDR_WIDTH  count latched from word 0 (after clamping).
- `cnt_err`  out  1  sticky flag: count clamped or an out-of-range write was dropped.
- `wr_req`  in  1  write request. Held with `wr_addr`/`wr_data` stable until granted.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write word.
- `wr_grant`  out  1  combinational, `wr_req & (state==IDLE)`.
- `mem_address`  out  ADDR_WIDTH  RAM address, registered.
- `mem_data`  out  DATA_WIDTH  RAM write data, registered.
- `mem_rden`  out  1  RAM read enable, registered.
- `mem_wren`  out  1  RAM write enable, registered.
- `mem_q`  in  DATA_WIDTH  RAM read data, valid 2 cycles after the address cycle.

## Operation
- **FSM states:** IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN, DONE.
- **IDLE:**
  - If `wr_req`: grant it. The next cycle drives `mem_wren=1`, `mem_address=wr_addr`, `mem_data=wr_data`.
  - If `wr_addr >= PARTICLE_NUM`, the write is granted but not performed: `mem_wren` stays 0 and `cnt_err` is set.
  - A `rd_start` pulse is latched into `rd_pend`.
  - When `rd_pend` (or `rd_start`) is set and `wr_req=0`, go to CNT_RD. Writes win ties; the latched start begins on the first cycle with no write.
- **CNT_RD:** drive `mem_address=0`, `mem_rden=1` for one cycle, then go to CNT_WAIT.
- **CNT_WAIT:**
  - Wait until `mem_q` is valid.
  - Capture `mem_q[ADDR_WIDTH-1:0]` into `cell_count`. If it exceeds `PARTICLE_NUM-1`, clamp it to `PARTICLE_NUM-1` and set `cnt_err`.
  - Count 0 goes to DONE; otherwise go to STREAM.
- **STREAM:** issue addresses 1..N, one per cycle, with `mem_rden=1`. After address N, go to DRAIN.
- **DRAIN:** hold `mem_rden=0` until the last `rd_valid` has been emitted, then go to DONE.
- **DONE:** one cycle with `rd_done=1`, then return to IDLE.
- **Read return path:** a 2-stage valid/index shift register tracks outstanding reads. `rd_data`, `rd_index` and `rd_valid` are registered from `mem_q` one cycle after the data returns.
- **Write blocking:** `wr_grant=0` in every non-IDLE state, so no read-during-write ever reaches the RAM.
- **Ignored starts:** `rd_start` while `rd_busy=1` is ignored and is not latched.
- **`cnt_err`:** cleared only by `rst`.

## Timing
- **Reset values:** all outputs are 0 one cycle after `rst` is sampled high. `rd_pend`, the state and the return pipeline are cleared.
- **Reset mid-stream:** aborts the stream. No `rd_valid` and no `rd_done` follow.
- **Read stream,** with `rd_start` sampled in cycle T in IDLE and no write pending:
  - `rd_busy=1` from T+1.
  - Address 0 is presented in T+1, and `cell_count` is updated at the end of T+3.
  - Address k (1..N) is presented in T+3+k.
  - `rd_valid` for index k is asserted in T+6+k, contiguously with no gaps.
  - `rd_done` is asserted in T+7+N. `rd_busy` falls in T+8+N.
- **N=0:** `rd_done` in T+4, no `rd_valid`.
- **Earliest restart:** the next `rd_start` is accepted in the cycle after `rd_done`.
- **Write:** grant in cycle G, `mem_wren` in G+1. Write throughput is 1 per cycle while in IDLE.
- **Simultaneous start and write in IDLE:** a write granted in cycle G together with a start delays the start. Address 0 is issued in the first following cycle with `wr_req=0`.

## Test plan
- **Normal stream:** RAM word 0 = 3, words 1..3 = A,B,C; `rd_start` at T -> `rd_valid` at T+7..T+9 with indices 1,2,3 and data A,B,C; `rd_done` at T+10; `cell_count=3`.
- **Empty cell:** word 0 = 0 -> `rd_done` at T+4, no `rd_valid`, `cell_count=0`.
- **Write during stream:** `wr_req` held from T+2 during an N=3 stream -> `wr_grant=0` until IDLE; `mem_wren` one cycle after the grant; readback shows the new value.
- **Start/write tie:** `rd_start` and `wr_req` in the same IDLE cycle -> write performed first; `mem_rden` with address 0 one cycle after the write cycle; stream completes correctly.
- **Overflow and bad address:** word 0 = 250 -> `cell_count=219`, `cnt_err=1`, exactly 219 `rd_valid`. A write to address 230 -> granted, no `mem_wren`, `cnt_err=1`.
- **Reset mid-stream:** `rst` asserted in T+8 of an N=5 stream -> all outputs 0 the next cycle, no further `rd_valid`/`rd_done`; a new `rd_start` afterwards streams normally.
